// File: rtl/control_fsm.sv
// control_fsm: multicycle Moore control unit for the TinyV datapath.
// Sequences fetch/decode/execute/memory/writeback from the opcode returned by the
// datapath. It also provides run/step gating, halt/illegal detection and a
// retired-instruction counter.
module control_fsm #(
  parameter int                      OPCODE_WIDTH = 6,
  parameter int                      ALU_SEL_SIZE = 4,
  parameter int                      CNT_W        = 32,
  parameter logic [ALU_SEL_SIZE-1:0] ALU_ADD      = ALU_SEL_SIZE'(4'h0),
  parameter logic [ALU_SEL_SIZE-1:0] ALU_SEQ      = ALU_SEL_SIZE'(4'hA),
  parameter logic [ALU_SEL_SIZE-1:0] ALU_PASSA    = ALU_SEL_SIZE'(4'hF)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic [OPCODE_WIDTH-1:0] codop,
  output logic [1:0]              pcWrSel,
  output logic                    pcCtrl,
  output logic                    memAdrSel,
  output logic                    memWrCtl,
  output logic [ALU_SEL_SIZE-1:0] aluOp,
  output logic                    aluASel,
  output logic [1:0]              aluBSel,
  output logic                    regWCtl,
  output logic                    regDataSel,
  output logic [1:0]              regWSel,
  output logic                    halted,
  output logic                    illegal,
  output logic                    retire,
  output logic [CNT_W-1:0]        instr_count,
  output logic [3:0]              state_dbg
);

  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(6'h10);
  localparam logic [OPCODE_WIDTH-1:0] OP_LW   = OPCODE_WIDTH'(6'h11);
  localparam logic [OPCODE_WIDTH-1:0] OP_SW   = OPCODE_WIDTH'(6'h12);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  = OPCODE_WIDTH'(6'h13);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = OPCODE_WIDTH'(6'h14);
  localparam logic [OPCODE_WIDTH-1:0] OP_JAL  = OPCODE_WIDTH'(6'h15);
  localparam logic [OPCODE_WIDTH-1:0] OP_HALT = OPCODE_WIDTH'(6'h3F);

  // Encoding follows the order the states are introduced; state_dbg exposes it.
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC_R, ALU_WB, EXEC_I, ALUI_WB, MEM_ADDR,
    MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, JAL_LINK, JAL_WB, HALT
  } state_t;

  typedef struct packed {
    logic [1:0]              pc_wr_sel;
    logic                    pc_ctrl;
    logic                    mem_adr_sel;
    logic                    mem_wr_ctl;
    logic [ALU_SEL_SIZE-1:0] alu_op;
    logic                    alu_a_sel;
    logic [1:0]              alu_b_sel;
    logic                    reg_w_ctl;
    logic                    reg_data_sel;
    logic [1:0]              reg_w_sel;
  } ctl_t;

  state_t                  state;
  state_t                  next_state;
  logic [OPCODE_WIDTH-1:0] opcode_q;
  logic [OPCODE_WIDTH-1:0] opc_next;
  logic                    retire_next;
  ctl_t                    ctl_q;

  function automatic logic is_rtype(input logic [OPCODE_WIDTH-1:0] op);
    return op[OPCODE_WIDTH-1 -: 2] == 2'b00;
  endfunction

  function automatic logic is_legal(input logic [OPCODE_WIDTH-1:0] op);
    return is_rtype(op) ||
           (op inside {OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_JMP, OP_JAL, OP_HALT});
  endfunction

  function automatic state_t next_of(input state_t s, input logic go,
                                     input logic [OPCODE_WIDTH-1:0] cod,
                                     input logic [OPCODE_WIDTH-1:0] opc);
    state_t n;
    // NOTE: start from a default so every path assigns n and no latch can be inferred.
    n = IDLE;
    case (s)
      IDLE:     n = go ? FETCH : IDLE;
      FETCH:    n = DECODE;
      DECODE: begin
        if (is_rtype(cod)) n = EXEC_R;
        else begin
          case (cod)
            OP_ADDI:      n = EXEC_I;
            OP_LW, OP_SW: n = MEM_ADDR;
            OP_BEQ:       n = BRANCH;
            OP_JMP:       n = JUMP;
            OP_JAL:       n = JAL_LINK;
            default:      n = HALT;
          endcase
        end
      end
      EXEC_R:   n = ALU_WB;
      EXEC_I:   n = ALUI_WB;
      MEM_ADDR: n = (opc == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:   n = MEM_WB;
      JAL_LINK: n = JAL_WB;
      HALT:     n = HALT;
      default:  n = IDLE;
    endcase
    return n;
  endfunction

  // Control word for a state; opc is the opcode that will be latched in that state.
  function automatic ctl_t ctl_for(input state_t s, input logic [OPCODE_WIDTH-1:0] opc);
    ctl_t c;
    c        = '0;
    c.alu_op = ALU_ADD;
    case (s)
      FETCH:    begin c.alu_b_sel = 2'd1; c.pc_ctrl = 1'b1; end
      DECODE:   c.alu_b_sel = 2'd2;
      EXEC_R:   begin c.alu_a_sel = 1'b1; c.alu_op = ALU_SEL_SIZE'(opc[3:0]); end
      ALU_WB:   begin c.reg_w_ctl = 1'b1; c.reg_data_sel = 1'b1; end
      EXEC_I,
      MEM_ADDR: begin c.alu_a_sel = 1'b1; c.alu_b_sel = 2'd2; end
      ALUI_WB:  begin c.reg_w_ctl = 1'b1; c.reg_data_sel = 1'b1; c.reg_w_sel = 2'd1; end
      MEM_RD:   c.mem_adr_sel = 1'b1;
      MEM_WB:   begin c.reg_w_ctl = 1'b1; c.reg_w_sel = 2'd1; end
      MEM_WR:   begin c.mem_adr_sel = 1'b1; c.mem_wr_ctl = 1'b1; end
      BRANCH:   begin c.alu_a_sel = 1'b1; c.alu_op = ALU_SEQ; c.pc_wr_sel = 2'd1; end
      JUMP:     begin c.pc_wr_sel = 2'd2; c.pc_ctrl = 1'b1; end
      JAL_LINK: c.alu_op = ALU_PASSA;
      JAL_WB:   begin
        c.reg_w_ctl = 1'b1; c.reg_w_sel = 2'd2; c.reg_data_sel = 1'b1;
        c.pc_wr_sel = 2'd2; c.pc_ctrl = 1'b1;
      end
      default:  ;
    endcase
    return c;
  endfunction

  // Outputs are registered from the upcoming state so they line up with state_dbg.
  assign next_state  = next_of(state, run, codop, opcode_q);
  assign opc_next    = (state == DECODE) ? codop : opcode_q;
  assign retire_next = (next_state inside {ALU_WB, ALUI_WB, MEM_WB, MEM_WR, BRANCH, JUMP, JAL_WB}) ||
                       (state == DECODE && codop == OP_HALT);

  // State, latched opcode, registered control word, sticky flags and retire counter.
  always_ff @(posedge clk) begin
    // NOTE: every register here, including the control word, is reset so an aborted
    // instruction can never leave a write enable asserted.
    if (rst) begin
      state       <= IDLE;
      opcode_q    <= '0;
      ctl_q       <= ctl_for(IDLE, '0);
      halted      <= 1'b0;
      illegal     <= 1'b0;
      retire      <= 1'b0;
      instr_count <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state  <= next_state;
      ctl_q  <= ctl_for(next_state, opc_next);
      retire <= retire_next;
      if (state == DECODE) opcode_q <= codop;
      if (retire_next) instr_count <= instr_count + 1'b1;
      if (next_state == HALT) halted <= 1'b1;
      if (state == DECODE && !is_legal(codop)) illegal <= 1'b1;
    end
  end

  assign pcWrSel    = ctl_q.pc_wr_sel;
  assign pcCtrl     = ctl_q.pc_ctrl;
  assign memAdrSel  = ctl_q.mem_adr_sel;
  assign memWrCtl   = ctl_q.mem_wr_ctl;
  assign aluOp      = ctl_q.alu_op;
  assign aluASel    = ctl_q.alu_a_sel;
  assign aluBSel    = ctl_q.alu_b_sel;
  assign regWCtl    = ctl_q.reg_w_ctl;
  assign regDataSel = ctl_q.reg_data_sel;
  assign regWSel    = ctl_q.reg_w_sel;
  assign state_dbg  = state;

endmodule
